// File: rtl/dmem_pipe_pkg.sv
// Shared definitions for the MEM-stage data memory: access sizes, stage payload, legality helper.
package dmem_pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LANES  = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // One pipeline stage: everything the final stage needs to build the response.
    typedef struct packed {
        logic              valid;
        logic              is_load;
        logic              err;
        logic [1:0]        size;
        logic              sign_ext;
        logic [1:0]        lane;
        logic [DATA_W-1:0] word;
    } stage_t;

    // Reserved size 2'b11 falls into the word case, so it is checked like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lane[0];
            default: mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_pipe_if.sv
// Request/response bus between the EX/MEM register and the data memory.
interface dmem_pipe_if;
    import dmem_pipe_pkg::*;

    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rvalid, rdata, err
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rvalid, rdata, err
    );

endinterface

// File: rtl/dmem_load_align.sv
// Sub-word lane select and sign/zero extension of a loaded word.
module dmem_load_align
    import dmem_pipe_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        lane_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Pick the addressed byte/half, then extend to full width.
    always_comb begin
        byte_c  = word_i[8*lane_i +: 8];
        half_c  = lane_i[1] ? word_i[31:16] : word_i[15:0];
        rdata_o = word_i;
        case (size_i)
            SZ_BYTE: rdata_o = {{24{sign_ext_i & byte_c[7]}}, byte_c};
            SZ_HALF: rdata_o = {{16{sign_ext_i & half_c[15]}}, half_c};
            default: rdata_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_pipe.sv
// Data memory for the MEM stage: byte-lane stores, pipelined sub-word loads, access error flag.
module dmem_pipe
    import dmem_pipe_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_pipe_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     idx_c;
    logic [1:0]        lane_c;
    logic              oor_c;
    logic              illegal_c;
    logic              store_c;
    logic [LANES-1:0]  be_c;
    logic [DATA_W-1:0] wrep_c;
    stage_t            stage_in_c;
    stage_t            last_c;
    logic [DATA_W-1:0] aligned_c;

    logic              rvalid_d, rvalid_q;
    logic              err_d,    err_q;
    logic [DATA_W-1:0] rdata_d,  rdata_q;

    assign idx_c     = bus.addr[AW+1:2];
    assign lane_c    = bus.addr[1:0];
    assign oor_c     = (bus.addr >> (AW + 2)) != '0;
    assign illegal_c = oor_c | is_misaligned(bus.size, lane_c);
    assign store_c   = bus.req & bus.we & ~illegal_c;

    // Byte-lane enables and right-justified store data replicated into every lane.
    always_comb begin
        be_c   = '0;
        wrep_c = bus.wdata;
        case (bus.size)
            SZ_BYTE: begin
                be_c[lane_c] = 1'b1;
                wrep_c       = {4{bus.wdata[7:0]}};
            end
            SZ_HALF: begin
                be_c   = lane_c[1] ? 4'b1100 : 4'b0011;
                wrep_c = {2{bus.wdata[15:0]}};
            end
            default: be_c = 4'b1111;
        endcase
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (store_c) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (be_c[l]) mem_q[idx_c][8*l +: 8] <= wrep_c[8*l +: 8];
            end
        end
    end

    // Stage-1 payload; the array word is read at the accepting edge.
    always_comb begin
        stage_in_c          = '0;
        stage_in_c.valid    = bus.req;
        stage_in_c.is_load  = ~bus.we;
        stage_in_c.err      = illegal_c;
        stage_in_c.size     = bus.size;
        stage_in_c.sign_ext = bus.sign_ext;
        stage_in_c.lane     = lane_c;
        stage_in_c.word     = mem_q[idx_c];
    end

    for (genvar g = 0; g < int'(LATENCY); g++) begin : g_stage
        stage_t stage_q;

        // Free-running shift stage; reset drops anything in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else if (g == 0) begin
                stage_q <= stage_in_c;
            end else begin
                stage_q <= g_stage[(g > 0) ? g - 1 : 0].stage_q;
            end
        end
    end

    assign last_c = g_stage[LATENCY-1].stage_q;

    dmem_load_align u_align (
        .word_i     (last_c.word),
        .lane_i     (last_c.lane),
        .size_i     (last_c.size),
        .sign_ext_i (last_c.sign_ext),
        .rdata_o    (aligned_c)
    );

    // Response build: errored loads return zero, stores only raise err.
    always_comb begin
        rvalid_d = last_c.valid & last_c.is_load;
        err_d    = last_c.valid & last_c.err;
        rdata_d  = rdata_q;
        if (rvalid_d) rdata_d = last_c.err ? '0 : aligned_c;
    end

    // Registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe: one stream drives a LATENCY=1 and a LATENCY=3 instance.
module tb_dmem_pipe;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ervalid;
        logic        eerr;
        logic [31:0] erdata;
    } vec_t;

    localparam int NV = 28;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [NV];

    dmem_pipe_if b1 ();
    dmem_pipe_if b3 ();

    assign b3.req      = b1.req;
    assign b3.we       = b1.we;
    assign b3.size     = b1.size;
    assign b3.sign_ext = b1.sign_ext;
    assign b3.addr     = b1.addr;
    assign b3.wdata    = b1.wdata;

    dmem_pipe #(.DEPTH(1024), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    dmem_pipe #(.DEPTH(1024), .LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sx,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic ervalid, input logic eerr, input logic [31:0] erdata);
        vec_t v;
        v.we = we; v.size = size; v.sx = sx; v.addr = addr; v.wdata = wdata;
        v.ervalid = ervalid; v.eerr = eerr; v.erdata = erdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic sx,
                         input logic [31:0] addr, input logic [31:0] wdata);
        b1.req = 1'b1; b1.we = we; b1.size = size; b1.sign_ext = sx;
        b1.addr = addr; b1.wdata = wdata;
    endtask

    task automatic idle();
        b1.req = 1'b0; b1.we = 1'b0; b1.size = 2'b00; b1.sign_ext = 1'b0;
        b1.addr = '0; b1.wdata = '0;
    endtask

    // Isolated access: check both instances at their own latency, then the pulse ending.
    task automatic run_vec(input vec_t v, input int id);
        drive(v.we, v.size, v.sx, v.addr, v.wdata);
        @(negedge clk); idle();
        @(negedge clk);
        chk($sformatf("v%0d L1 rvalid", id), 32'(b1.rvalid), 32'(v.ervalid));
        chk($sformatf("v%0d L1 err", id), 32'(b1.err), 32'(v.eerr));
        if (v.ervalid) chk($sformatf("v%0d L1 rdata", id), b1.rdata, v.erdata);
        @(negedge clk);
        chk($sformatf("v%0d L1 rvalid end", id), 32'(b1.rvalid | b1.err), 32'd0);
        chk($sformatf("v%0d L3 early", id), 32'(b3.rvalid | b3.err), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d L3 rvalid", id), 32'(b3.rvalid), 32'(v.ervalid));
        chk($sformatf("v%0d L3 err", id), 32'(b3.err), 32'(v.eerr));
        if (v.ervalid) chk($sformatf("v%0d L3 rdata", id), b3.rdata, v.erdata);
        @(negedge clk);
        chk($sformatf("v%0d L3 rvalid end", id), 32'(b3.rvalid | b3.err), 32'd0);
    endtask

    initial begin
        logic [31:0] d [4];

        vecs[0]  = mk(1, 2'b10, 0, 32'h10,       32'hDEADBEEF, 0, 0, 32'h0);
        vecs[1]  = mk(0, 2'b10, 0, 32'h10,       32'h0,        1, 0, 32'hDEADBEEF);
        vecs[2]  = mk(1, 2'b00, 0, 32'h13,       32'h00000080, 0, 0, 32'h0);
        vecs[3]  = mk(0, 2'b00, 1, 32'h13,       32'h0,        1, 0, 32'hFFFFFF80);
        vecs[4]  = mk(0, 2'b00, 0, 32'h13,       32'h0,        1, 0, 32'h00000080);
        vecs[5]  = mk(0, 2'b10, 0, 32'h10,       32'h0,        1, 0, 32'h80ADBEEF);
        vecs[6]  = mk(1, 2'b01, 0, 32'h12,       32'h00001234, 0, 0, 32'h0);
        vecs[7]  = mk(0, 2'b01, 1, 32'h12,       32'h0,        1, 0, 32'h00001234);
        vecs[8]  = mk(0, 2'b10, 0, 32'h10,       32'h0,        1, 0, 32'h1234BEEF);
        vecs[9]  = mk(1, 2'b10, 0, 32'h11,       32'hFFFFFFFF, 0, 1, 32'h0);
        vecs[10] = mk(0, 2'b01, 0, 32'h13,       32'h0,        1, 1, 32'h0);
        vecs[11] = mk(0, 2'b10, 0, 32'h10,       32'h0,        1, 0, 32'h1234BEEF);
        vecs[12] = mk(0, 2'b01, 1, 32'h10,       32'h0,        1, 0, 32'hFFFFBEEF);
        vecs[13] = mk(0, 2'b00, 0, 32'h11,       32'h0,        1, 0, 32'h000000BE);
        vecs[14] = mk(0, 2'b00, 1, 32'h11,       32'h0,        1, 0, 32'hFFFFFFBE);
        vecs[15] = mk(0, 2'b11, 1, 32'h10,       32'h0,        1, 0, 32'h1234BEEF);
        vecs[16] = mk(0, 2'b11, 0, 32'h12,       32'h0,        1, 1, 32'h0);
        vecs[17] = mk(1, 2'b10, 0, 32'h0,        32'h11223344, 0, 0, 32'h0);
        vecs[18] = mk(1, 2'b01, 0, 32'h2,        32'h0000CAFE, 0, 0, 32'h0);
        vecs[19] = mk(1, 2'b00, 0, 32'h0,        32'hFFFFFF55, 0, 0, 32'h0);
        vecs[20] = mk(0, 2'b10, 0, 32'h0,        32'h0,        1, 0, 32'hCAFE3355);
        vecs[21] = mk(1, 2'b10, 0, 32'h1000,     32'hFFFFFFFF, 0, 1, 32'h0);
        vecs[22] = mk(0, 2'b10, 0, 32'h1000,     32'h0,        1, 1, 32'h0);
        vecs[23] = mk(0, 2'b10, 0, 32'h80000010, 32'h0,        1, 1, 32'h0);
        vecs[24] = mk(0, 2'b01, 0, 32'h2,        32'h0,        1, 0, 32'h0000CAFE);
        vecs[25] = mk(1, 2'b01, 0, 32'h11,       32'h0000AAAA, 0, 1, 32'h0);
        vecs[26] = mk(0, 2'b10, 0, 32'h0,        32'h0,        1, 0, 32'hCAFE3355);
        vecs[27] = mk(0, 2'b10, 0, 32'h10,       32'h0,        1, 0, 32'h1234BEEF);

        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        chk("reset L1 rvalid", 32'(b1.rvalid), 32'd0);
        chk("reset L1 err", 32'(b1.err), 32'd0);
        chk("reset L1 rdata", b1.rdata, 32'd0);
        chk("reset L3 rvalid", 32'(b3.rvalid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Store then load of the same word on the very next cycle.
        drive(1, 2'b10, 0, 32'h20, 32'h0BADF00D);
        @(negedge clk);
        drive(0, 2'b10, 0, 32'h20, 32'h0);
        @(negedge clk); idle();
        chk("raw L1 no resp for store", 32'(b1.rvalid | b1.err), 32'd0);
        @(negedge clk);
        chk("raw L1 rvalid", 32'(b1.rvalid), 32'd1);
        chk("raw L1 rdata", b1.rdata, 32'h0BADF00D);
        @(negedge clk);
        chk("raw L3 early", 32'(b3.rvalid), 32'd0);
        @(negedge clk);
        chk("raw L3 rvalid", 32'(b3.rvalid), 32'd1);
        chk("raw L3 rdata", b3.rdata, 32'h0BADF00D);
        @(negedge clk);

        // Four back-to-back stores then four back-to-back loads.
        for (int i = 0; i < 4; i++) d[i] = 32'hC0DE0000 | (32'(i) * 32'h111);
        for (int c = 0; c < 14; c++) begin
            if (c < 4)      drive(1, 2'b10, 0, 32'(c * 4), d[c]);
            else if (c < 8) drive(0, 2'b10, 0, 32'((c - 4) * 4), 32'h0);
            else            idle();
            @(negedge clk);
            chk($sformatf("b2b c%0d L1 rvalid", c), 32'(b1.rvalid), 32'(c >= 5 && c <= 8));
            chk($sformatf("b2b c%0d L3 rvalid", c), 32'(b3.rvalid), 32'(c >= 7 && c <= 10));
            chk($sformatf("b2b c%0d err", c), 32'(b1.err | b3.err), 32'd0);
            if (c >= 5 && c <= 8)  chk($sformatf("b2b c%0d L1 rdata", c), b1.rdata, d[c-5]);
            if (c >= 7 && c <= 10) chk($sformatf("b2b c%0d L3 rdata", c), b3.rdata, d[c-7]);
        end
        idle();
        @(negedge clk);

        // Leave a nonzero rdata on both outputs, then reset with a load in flight.
        run_vec(mk(0, 2'b10, 0, 32'h10, 32'h0, 1, 0, 32'h1234BEEF), 100);
        drive(0, 2'b10, 0, 32'h10, 32'h0);
        @(negedge clk); idle();
        rst_n = 1'b0;
        #1;
        chk("rst mid L1 rvalid", 32'(b1.rvalid), 32'd0);
        chk("rst mid L1 err", 32'(b1.err), 32'd0);
        chk("rst mid L1 rdata", b1.rdata, 32'd0);
        chk("rst mid L3 rvalid", 32'(b3.rvalid), 32'd0);
        chk("rst mid L3 rdata", b3.rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post rst c%0d rvalid", c), 32'(b1.rvalid | b3.rvalid), 32'd0);
        end
        run_vec(mk(0, 2'b10, 0, 32'h10, 32'h0, 1, 0, 32'h1234BEEF), 101);
        run_vec(mk(0, 2'b10, 0, 32'h0, 32'h0, 1, 0, d[0]), 102);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
